// File: rtl/cfg_master.sv
// Register-bus initiator: buffers read/write commands in a FIFO, issues each
// as a single-cycle strobe, waits for read data with a timeout, returns ordered responses.
module cfg_master #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          cmd_vld,
   output logic          cmd_rdy,
   input  logic          cmd_wr,
   input  logic [AW-1:0] cmd_addr,
   input  logic [DW-1:0] cmd_wdata,
   output logic          rsp_vld,
   input  logic          rsp_rdy,
   output logic [DW-1:0] rsp_data,
   output logic          rsp_err,
   output logic          rsp_wr,
   output logic [AW-1:0] addr,
   output logic [DW-1:0] wdata,
   output logic          wr,
   output logic          rd,
   input  logic [DW-1:0] rdata,
   input  logic          rdata_vld,
   output logic          busy
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef struct packed {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } cmd_t;

   typedef enum logic [1:0] {
      IDLE,
      STROBE,
      WAIT,
      RESP
   } state_t;

   state_t state, state_nxt;

   cmd_t          mem [DEPTH];
   cmd_t          head;
   logic [PW:0]   wp, rp;
   logic          empty, full, push, pop;
   logic          cur_wr;
   logic [CW-1:0] cnt;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty   = (wp == rp);
   assign full    = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
   assign cmd_rdy = rstn && !full;
   assign push    = cmd_vld && cmd_rdy;
   assign pop     = (state == IDLE) && !empty;
   assign head    = mem[rp[PW-1:0]];
   assign rsp_vld = (state == RESP);
   assign busy    = !empty || (state != IDLE);

   // NOTE: storage array has no reset; emptiness is defined by the pointers alone.
   always_ff @(posedge clk) begin
      if (push) mem[wp[PW-1:0]] <= '{wr: cmd_wr, addr: cmd_addr, wdata: cmd_wdata};
   end

   // NOTE: all clocked state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop)  rp <= rp + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   // NOTE: next state defaults to the current state before the case, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (!empty) state_nxt = STROBE;
         STROBE:  state_nxt = cur_wr ? RESP : WAIT;
         WAIT:    if (rdata_vld || (cnt == CNT_LAST)) state_nxt = RESP;
         RESP:    if (rsp_rdy) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         addr     <= '0;
         wdata    <= '0;
         wr       <= 1'b0;
         rd       <= 1'b0;
         cur_wr   <= 1'b0;
         cnt      <= '0;
         rsp_data <= '0;
         rsp_err  <= 1'b0;
         rsp_wr   <= 1'b0;
      end else begin
         // Strobes are one cycle wide: set on the pop, cleared on the next edge.
         wr <= 1'b0;
         rd <= 1'b0;
         case (state)
            IDLE: begin
               if (!empty) begin
                  addr   <= head.addr;
                  wdata  <= head.wdata;
                  wr     <= head.wr;
                  rd     <= !head.wr;
                  cur_wr <= head.wr;
               end
            end
            STROBE: begin
               cnt <= '0;
               if (cur_wr) begin
                  rsp_data <= '0;
                  rsp_err  <= 1'b0;
                  rsp_wr   <= 1'b1;
               end
            end
            WAIT: begin
               if (rdata_vld) begin
                  rsp_data <= rdata;
                  rsp_err  <= 1'b0;
                  rsp_wr   <= 1'b0;
               end else if (cnt == CNT_LAST) begin
                  rsp_data <= '0;
                  rsp_err  <= 1'b1;
                  rsp_wr   <= 1'b0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/cfg_master.md
# cfg_master

Bus initiator for the register configuration bus (`addr`/`wdata`/`wr`/`rd` out, `rdata`/`rdata_vld` in). It accepts read/write commands from a firmware sequencer or test controller through a valid/ready command port and buffers them in a small FIFO. It issues each command on the bus as a single-cycle strobe, waits for read data with a timeout, and returns one ordered response per command. It sits upstream of the `cfg` register block and drives that block's bus inputs directly.

## Interface
- `AW`, 32: address width
- `DW`, 32: data width
- `DEPTH`, 4: command FIFO depth; power of two, ≥2
- `TIMEOUT`, 16: cycles to wait for `rdata_vld` after `rd`; 1..255
- `clk` in 1: clock
- `rstn` in 1: reset; asynchronous, active-low; one clock domain
- `cmd_vld` in 1: command valid
- `cmd_rdy` out 1: command ready (`!fifo_full`)
- `cmd_wr` in 1: 1 = write, 0 = read
- `cmd_addr` in AW: command address
- `cmd_wdata` in DW: write data (ignored for reads)
- `rsp_vld` out 1: response valid
- `rsp_rdy` in 1: response ready
- `rsp_data` out DW: read data; 0 for writes and timeouts
- `rsp_err` out 1: read timed out
- `rsp_wr` out 1: response belongs to a write
- `addr` out AW: bus address
- `wdata` out DW: bus write data
- `wr` out 1: bus write strobe
- `rd` out 1: bus read strobe
- `rdata` in DW: bus read data
- `rdata_vld` in 1: bus read data valid
- `busy` out 1: FIFO non-empty or FSM not in IDLE

## Operation
- Command push: `cmd_vld && cmd_rdy` on a rising edge.
  - Entry is `{cmd_wr, cmd_addr, cmd_wdata}`.
  - A push while full cannot occur, because `cmd_rdy` is low.
  - Push and pop in the same cycle are both legal, including when full (push is still blocked by `cmd_rdy`) and when empty (popped data is not the same-cycle push).
- FSM states and transitions:
  - IDLE: if the FIFO is non-empty, pop the head and register the bus outputs. Drive `wr` = entry.wr or `rd` = !entry.wr, plus `addr`/`wdata`. Go to STROBE.
  - STROBE: strobe visible for exactly this cycle. Writes go to RESP. Reads clear the timeout counter and go to WAIT.
  - WAIT: sample `rdata_vld` every cycle.
    - If seen: capture `rdata`, set err=0, go to RESP.
    - Else if the counter reaches TIMEOUT-1: set data=0, err=1, go to RESP.
    - Otherwise increment the counter.
  - RESP: hold `rsp_vld`=1 and stable fields until `rsp_rdy`. On handshake go to IDLE.
- `wr`/`rd` are never both high and are high for at most one cycle per command. `addr`/`wdata` hold their last values between commands (no glitching back to 0).
- `rdata_vld` outside WAIT is ignored. This covers stray pulses and late data after a timeout.
- Commands are strictly serialised: one outstanding bus transaction, and responses return in command order.
- Counter is `$clog2(TIMEOUT+1)` bits and never wraps.
- Reset (asynchronous, any state, including mid-WAIT or mid-RESP):
  - FIFO emptied.
  - FSM to IDLE.
  - All outputs 0, except `cmd_rdy`=1 once reset is released.
  - Pending command and response are discarded.

## Timing
- Write accepted into an empty idle block at edge N:
  - `wr` high in cycle N+2.
  - `rsp_vld` high in cycle N+3.
- Read: `rd` high in cycle N+2. `rdata_vld` is sampled from cycle N+3.
  - If `rdata_vld` is seen in cycle M, `rsp_vld` is high in cycle M+1 with `rsp_data`=`rdata`@M.
  - If not seen, the timeout response is issued at cycle N+3+TIMEOUT.
- Back-to-back throughput:
  - Write with `rsp_rdy` tied high: one command per 3 cycles (IDLE, STROBE, RESP).
  - Read: 4 cycles plus bus latency.
- `cmd_rdy` deasserts the cycle after the push that fills the FIFO. It reasserts the cycle after the pop.
- `rsp_*` outputs are registered. `rsp_vld` stays high indefinitely under backpressure, and no new strobe is issued while in RESP.

## Test plan
- Reset values: assert `rstn`=0 mid-WAIT.
  - Required: outputs immediately 0 and FIFO empty.
  - After release: `cmd_rdy`=1 and `busy`=0.
- Single write: push `wr` to addr 0x8, data 0xA5A5_0001 at N.
  - Required: `wr`=1 only in cycle N+2 with matching `addr`/`wdata`.
  - Required: `rsp_vld` at N+3 with `rsp_wr`=1, `rsp_err`=0.
- Read with data: push read of 0x10; the bus model returns 0x1234_5678 two cycles after `rd`.
  - Required: `rsp_data`=0x1234_5678, `rsp_err`=0, `rsp_vld` one cycle after `rdata_vld`.
- Timeout: TIMEOUT=16, bus never returns data.
  - Required: `rsp_err`=1 and `rsp_data`=0 at `rd`-cycle+17.
  - A `rdata_vld` pulse injected afterwards is ignored, and the next command proceeds normally.
- FIFO full with backpressure: hold `rsp_rdy`=0 and push 6 writes.
  - Required: `cmd_rdy` drops after DEPTH+1 accepted (4 in FIFO plus 1 in flight).
  - Release `rsp_rdy`: all 5 responses arrive in order, each strobe occurs exactly once, and `busy` falls after the last handshake.
- Mixed ordering: alternate write/read to the same address through the `cfg` model.
  - Required: each read returns the data of the preceding write, and `wr`/`rd` are never high together.
